// File: rtl/apu_ain.sv
// apu_ain: stereo PDM microphone receiver. Two mics share one data line; each channel
// is decimated by a 3rd-order CIC to signed 16-bit PCM, and {left,right} goes out on valid/ready.
module apu_ain #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  clkdiv,
  output logic        pdm_clk,
  input  logic        pdm_dat,
  output logic [31:0] sample,
  output logic        sample_vld,
  input  logic        sample_rdy,
  output logic        overrun
);

  localparam int W     = 3 * DECIM_LOG2 + 2;
  localparam int SHIFT = 3 * DECIM_LOG2 - 15;
  localparam logic [DECIM_LOG2-1:0] FRAME_LAST = '1;
  localparam logic [W-1:0]          STEP_UP    = W'(1);
  localparam logic [W-1:0]          STEP_DN    = '1;
  localparam logic signed [W-1:0]   PCM_MAX    = W'(32767);
  localparam logic signed [W-1:0]   PCM_MIN    = W'(-32768);

  logic                  sync1, sync2;
  logic [7:0]            div_cnt;
  logic                  tick;
  logic                  started;
  logic [DECIM_LOG2-1:0] frame_cnt;
  logic                  l_bit, r_bit, l_upd, r_upd;
  logic                  win_end, win_d, comb_vld;
  logic [W-1:0]          l_i1, l_i2, l_i3, r_i1, r_i2, r_i3;
  logic [W-1:0]          l_n1, l_n2, l_n3, r_n1, r_n2, r_n3;
  logic [W-1:0]          l_d1, l_d2, l_d3, l_c3, r_d1, r_d2, r_d3, r_c3;
  logic [W-1:0]          l_k1, l_k2, l_k3, r_k1, r_k2, r_k3;
  logic [1:0]            settle_cnt;
  logic                  load;

  function automatic logic [15:0] to_pcm(input logic [W-1:0] acc);
    logic signed [W-1:0] y;
    y = $signed(acc) >>> SHIFT;
    if (y > PCM_MAX)      return 16'h7fff;
    else if (y < PCM_MIN) return 16'h8000;
    else                  return 16'(y);
  endfunction

  // The synchronizer is deliberately left running while disabled so the first
  // capture after enable already sees real line data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_dat;
      sync2 <= sync1;
    end
  end

  assign tick = (div_cnt == 8'd0);

  // The rising edge right after enable has no left bit before it, so right captures wait for `started`.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      pdm_clk   <= 1'b0;
      started   <= 1'b0;
      frame_cnt <= '0;
      l_bit     <= 1'b0;
      r_bit     <= 1'b0;
      l_upd     <= 1'b0;
      r_upd     <= 1'b0;
      win_end   <= 1'b0;
    end else if (!en) begin
      div_cnt   <= '0;
      pdm_clk   <= 1'b0;
      started   <= 1'b0;
      frame_cnt <= '0;
      l_bit     <= 1'b0;
      r_bit     <= 1'b0;
      l_upd     <= 1'b0;
      r_upd     <= 1'b0;
      win_end   <= 1'b0;
    end else begin
      l_upd   <= 1'b0;
      r_upd   <= 1'b0;
      win_end <= 1'b0;
      if (tick) begin
        div_cnt <= clkdiv;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt - 8'd1;
      end
      if (tick && pdm_clk) begin
        l_bit   <= sync2;
        l_upd   <= 1'b1;
        started <= 1'b1;
      end
      if (tick && !pdm_clk && started) begin
        r_bit     <= sync2;
        r_upd     <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
        win_end   <= (frame_cnt == FRAME_LAST);
      end
    end
  end

  always_comb begin
    l_n1 = l_i1 + (l_bit ? STEP_UP : STEP_DN);
    l_n2 = l_i2 + l_n1;
    l_n3 = l_i3 + l_n2;
    r_n1 = r_i1 + (r_bit ? STEP_UP : STEP_DN);
    r_n2 = r_i2 + r_n1;
    r_n3 = r_i3 + r_n2;
  end

  always_comb begin
    l_k1 = l_i3 - l_d1;
    l_k2 = l_k1 - l_d2;
    l_k3 = l_k2 - l_d3;
    r_k1 = r_i3 - r_d1;
    r_k2 = r_k1 - r_d2;
    r_k3 = r_k2 - r_d3;
  end

  // Integrators chain combinationally so each channel's new bit reaches stage 3 in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {l_i1, l_i2, l_i3, r_i1, r_i2, r_i3} <= '0;
      win_d <= 1'b0;
    end else if (!en) begin
      {l_i1, l_i2, l_i3, r_i1, r_i2, r_i3} <= '0;
      win_d <= 1'b0;
    end else begin
      win_d <= win_end;
      if (l_upd) begin
        l_i1 <= l_n1;
        l_i2 <= l_n2;
        l_i3 <= l_n3;
      end
      if (r_upd) begin
        r_i1 <= r_n1;
        r_i2 <= r_n2;
        r_i3 <= r_n3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {l_d1, l_d2, l_d3, l_c3, r_d1, r_d2, r_d3, r_c3} <= '0;
      comb_vld <= 1'b0;
    end else if (!en) begin
      {l_d1, l_d2, l_d3, l_c3, r_d1, r_d2, r_d3, r_c3} <= '0;
      comb_vld <= 1'b0;
    end else begin
      comb_vld <= win_d;
      if (win_d) begin
        l_d1 <= l_i3;
        l_d2 <= l_k1;
        l_d3 <= l_k2;
        l_c3 <= l_k3;
        r_d1 <= r_i3;
        r_d2 <= r_k1;
        r_d3 <= r_k2;
        r_c3 <= r_k3;
      end
    end
  end

  assign load = comb_vld && (settle_cnt == 2'd3);

  // A load in the same cycle as a handshake wins, so the consumer takes the old value and vld stays up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      sample     <= '0;
      sample_vld <= 1'b0;
      overrun    <= 1'b0;
    end else if (!en) begin
      settle_cnt <= '0;
      sample     <= '0;
      sample_vld <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (comb_vld && !load) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      if (load) begin
        sample     <= {to_pcm(l_c3), to_pcm(r_c3)};
        sample_vld <= 1'b1;
        overrun    <= sample_vld && !sample_rdy;
      end else if (sample_vld && sample_rdy) begin
        sample_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_ain.sv
// Bench for apu_ain: a CIC model built from FIR coefficients and PDM timing formulas
// is compared with the DUT every cycle, plus literal checks for the full-scale and timing cases.
module tb_apu_ain;

  localparam int L     = 6;
  localparam int R     = 1 << L;
  localparam int TAPS  = 3 * R - 2;
  localparam int SHIFT = 3 * L - 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  clkdiv = 8'd0;
  logic        pdm_dat = 1'b0;
  logic        sample_rdy = 1'b1;
  logic        pdm_clk, sample_vld, overrun;
  logic [31:0] sample;

  apu_ain #(.DECIM_LOG2(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clkdiv     (clkdiv),
    .pdm_clk    (pdm_clk),
    .pdm_dat    (pdm_dat),
    .sample     (sample),
    .sample_vld (sample_vld),
    .sample_rdy (sample_rdy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          mode = 1;
  bit          hist [int];
  bit          active = 1'b0;
  int          base = 0;
  int          dper = 1;
  bit          xl[$];
  bit          xr[$];
  int          outs = 0;
  int          due_q[$];
  logic [31:0] val_q[$];
  logic        exp_pdm = 1'b0;
  logic        exp_vld = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [31:0] exp_sample = '0;
  longint      h[TAPS];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_vld(input int budget, input string name, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (sample_vld) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL %s: got no sample_vld, expected one within %0d cycles", name, budget);
    end
  endtask

  // CIC output = FIR with taps of (1 + z^-1 + ... + z^-(R-1))^3 over the latest input bits.
  function automatic logic [15:0] cic_out(input bit x[$]);
    longint acc;
    int     n;
    acc = 0;
    n   = x.size();
    for (int j = 0; j < TAPS && j < n; j++) acc += x[n-1-j] ? h[j] : -h[j];
    acc = acc >>> SHIFT;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  initial begin
    longint tmp[2*R-1];
    for (int i = 0; i < 2*R-1; i++) tmp[i] = 0;
    for (int a = 0; a < R; a++) for (int b = 0; b < R; b++) tmp[a+b]++;
    for (int i = 0; i < TAPS; i++) h[i] = 0;
    for (int a = 0; a < 2*R-1; a++) for (int b = 0; b < R; b++) h[a+b] += tmp[a];
  end

  // pdm_clk toggles at base + k*(clkdiv+1); odd k captures left, even k>=2 captures right,
  // each taking the line value from two edges earlier. Every R-th right bit closes a window.
  always @(posedge clk) begin
    int          k;
    logic [31:0] v;
    bit          vld_pre;
    bit          ld;
    cyc++;
    hist[cyc] = pdm_dat;
    if (!rst_n || !en) begin
      active     = 1'b0;
      exp_pdm    = 1'b0;
      exp_vld    = 1'b0;
      exp_ovr    = 1'b0;
      exp_sample = '0;
      outs       = 0;
      xl.delete();
      xr.delete();
      due_q.delete();
      val_q.delete();
    end else begin
      vld_pre = exp_vld;
      ld      = 1'b0;
      v       = '0;
      exp_ovr = 1'b0;
      if (!active) begin
        active = 1'b1;
        base   = cyc;
        dper   = int'(clkdiv) + 1;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        v = val_q.pop_front();
        if (outs >= 3) ld = 1'b1;
        outs++;
      end
      if (ld) begin
        exp_ovr    = vld_pre && !sample_rdy;
        exp_vld    = 1'b1;
        exp_sample = v;
      end else if (vld_pre && sample_rdy) begin
        exp_vld = 1'b0;
      end
      if ((cyc - base) % dper == 0) begin
        k = (cyc - base) / dper;
        exp_pdm = ~exp_pdm;
        if (k % 2 == 1) begin
          xl.push_back(hist[cyc-2]);
        end else if (k >= 2) begin
          xr.push_back(hist[cyc-2]);
          if (xr.size() % R == 0) begin
            due_q.push_back(cyc + 3);
            val_q.push_back({cic_out(xl), cic_out(xr)});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("pdm_clk", 32'(pdm_clk), 32'(exp_pdm));
    check_output("sample_vld", 32'(sample_vld), 32'(exp_vld));
    check_output("sample", sample, exp_sample);
    check_output("overrun", 32'(overrun), 32'(exp_ovr));
  end

  // Line driver: patterned modes place the wanted bit where the DUT will capture it two edges later.
  always @(negedge clk) begin
    int kk;
    int k;
    bit v;
    bit left;
    v = 1'($urandom_range(0, 1));
    case (mode)
      0: v = 1'b0;
      1: v = 1'b1;
      2, 3: begin
        if (active) begin
          kk = cyc + 3 - base;
          if (kk % dper == 0) begin
            k    = kk / dper;
            left = (k % 2 == 1);
            if (mode == 2) v = left;
            else           v = left ? ((k / 2) % 2 == 0) : 1'b1;
          end
        end
      end
      default: ;
    endcase
    pdm_dat = v;
  end

  task automatic apply_stimulus_loads(input int n, input string name);
    int at;
    for (int i = 0; i < n; i++) begin
      wait_vld(400, name, at);
      @(negedge clk);
    end
  endtask

  initial begin
    int t1, t2, ovr_cnt, run;
    bit hit;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_pdm_clk", 32'(pdm_clk), 32'd0);
    check_output("reset_vld", 32'(sample_vld), 32'd0);
    check_output("reset_sample", sample, 32'd0);
    check_output("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full-scale positive, first-sample latency and output spacing.
    mode = 1;
    sample_rdy = 1'b1;
    en = 1'b1;
    wait_vld(700, "first_vld", t1);
    check_output("first_vld_latency", 32'(t1 - base), 32'd515);
    check_output("sample_pos_full", sample, 32'h7fff7fff);
    @(negedge clk);
    wait_vld(200, "second_vld", t2);
    check_output("sample_spacing", 32'(t2 - t1), 32'd128);
    check_output("sample_pos_full2", sample, 32'h7fff7fff);
    @(negedge clk);

    mode = 0;
    apply_stimulus_loads(3, "neg_loads");
    wait_vld(200, "neg_vld", t1);
    check_output("sample_neg_full", sample, 32'h80008000);
    @(negedge clk);

    mode = 2;
    apply_stimulus_loads(3, "route_loads");
    wait_vld(200, "route_vld", t1);
    check_output("sample_routing", sample, 32'h7fff8000);
    @(negedge clk);

    mode = 3;
    apply_stimulus_loads(3, "alt_loads");
    wait_vld(200, "alt_vld", t1);
    check_output("sample_alt_left", sample, 32'h00007fff);
    @(negedge clk);

    // Consumer stalls across two output periods.
    mode = 4;
    wait_vld(200, "ovr_sync", t1);
    @(negedge clk);
    sample_rdy = 1'b0;
    ovr_cnt = 0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
    end
    check_output("overrun_pulses", 32'(ovr_cnt), 32'd1);
    check_output("overrun_vld_held", 32'(sample_vld), 32'd1);

    // Ready asserted exactly in the load cycle while a sample is pending.
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (due_q.size() > 0 && due_q[0] == cyc + 1 && outs >= 3) begin
        sample_rdy = 1'b1;
        @(negedge clk);
        sample_rdy = 1'b0;
        check_output("load_with_rdy_overrun", 32'(overrun), 32'd0);
        check_output("load_with_rdy_vld", 32'(sample_vld), 32'd1);
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL load_with_rdy: got no load cycle, expected one within 300 cycles");
    end

    // Disable mid-window, then re-enable.
    repeat (40) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_output("disable_pdm_clk", 32'(pdm_clk), 32'd0);
    check_output("disable_vld", 32'(sample_vld), 32'd0);
    repeat (3) @(negedge clk);
    mode = 1;
    sample_rdy = 1'b1;
    en = 1'b1;
    wait_vld(700, "reenable_vld", t1);
    check_output("reenable_latency", 32'(t1 - base), 32'd515);
    check_output("reenable_sample", sample, 32'h7fff7fff);
    sample_rdy = 1'b0;

    // Asynchronous reset mid-frame with a sample held.
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_output("async_rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check_output("async_rst_vld", 32'(sample_vld), 32'd0);
    check_output("async_rst_sample", sample, 32'd0);
    check_output("async_rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Random line data, random back-pressure, random divider.
    for (int it = 0; it < 3; it++) begin
      en = 1'b0;
      clkdiv = 8'($urandom_range(0, 2));
      mode = 4;
      repeat (3) @(negedge clk);
      en = 1'b1;
      run = 6 * 2 * R * (int'(clkdiv) + 1);
      for (int c = 0; c < run; c++) begin
        @(negedge clk);
        sample_rdy = ($urandom_range(0, 3) != 0);
        if (it == 1 && c == run / 2) begin
          en = 1'b0;
          repeat (5) @(negedge clk);
          en = 1'b1;
        end
      end
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
